// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronizes NUM_SRC raw sources, latches
// edge or level pending state, and arbitrates by fixed priority (lowest index
// wins). Software claims the winner through a CLAIM read and completes it by
// writing the ID back to CLAIM.
module ext_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [1:0]         reg_addr_i,
  input  logic               reg_we_i,
  input  logic               reg_re_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               irq_ext_o
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_TRIGGER = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;
  localparam int         PAD          = 32 - NUM_SRC;

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] en_q, en_d, trig_q, trig_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, isv_q, isv_d;
  logic [NUM_SRC-1:0] elig, claim_oh, claim_set, cmpl_oh, edge_v;
  logic [1:0]         warm_q, warm_d;
  logic [4:0]         claim_id;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q;
  logic               rd_claim, wr_claim;

  assign rd_claim = reg_re_i && (reg_addr_i == ADDR_CLAIM);
  assign wr_claim = reg_we_i && (reg_addr_i == ADDR_CLAIM);
  assign elig     = pend_q & en_q & ~isv_q;

  // The edge detector sees stale zeros in s3 for the first cycles after
  // reset; edges are only trusted once the three-flop chain has filled, so a
  // source already high at reset release never latches an edge.
  always_comb begin
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    edge_v = (warm_q == 2'd3) ? (s2_q & ~s3_q) : '0;
  end

  // Fixed-priority pick: scan downward so the lowest eligible index wins.
  always_comb begin
    claim_id = '0;
    claim_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        claim_id    = 5'(i + 1);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  // Next state for in-service and pending. A claim and a complete never
  // touch the same bit (one needs isv=0, the other isv=1), so both may apply.
  // A fresh edge beats a claim clear on the same bit.
  always_comb begin
    claim_set = rd_claim ? claim_oh : '0;
    cmpl_oh   = '0;
    for (int i = 0; i < NUM_SRC; i++)
      cmpl_oh[i] = wr_claim && (reg_wdata_i == 32'(i + 1)) && isv_q[i];
    isv_d  = (isv_q | claim_set) & ~cmpl_oh;
    pend_d = (trig_q & ((pend_q & ~claim_set) | edge_v))
           | (~trig_q & s2_q & ~isv_d);
  end

  // Register writes; PENDING is read-only and upper bits are dropped.
  always_comb begin
    en_d   = en_q;
    trig_d = trig_q;
    if (reg_we_i && reg_addr_i == ADDR_ENABLE)  en_d   = reg_wdata_i[NUM_SRC-1:0];
    if (reg_we_i && reg_addr_i == ADDR_TRIGGER) trig_d = reg_wdata_i[NUM_SRC-1:0];
  end

  // Read mux samples pre-write state; data holds until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (reg_re_i) begin
      case (reg_addr_i)
        ADDR_ENABLE:  rdata_d = {{PAD{1'b0}}, en_q};
        ADDR_TRIGGER: rdata_d = {{PAD{1'b0}}, trig_q};
        ADDR_PENDING: rdata_d = {{PAD{1'b0}}, pend_q};
        default:      rdata_d = {27'd0, claim_id};
      endcase
    end
  end

  // Synchronizer chain plus a third flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      warm_q <= '0;
    end else begin
      s1_q   <= src_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      warm_q <= warm_d;
    end
  end

  // Control/status registers, read data and the interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= '0;
      trig_q  <= '0;
      pend_q  <= '0;
      isv_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      isv_q   <= isv_d;
      rdata_q <= rdata_d;
      irq_q   <= |elig;
    end
  end

  assign reg_rdata_o = rdata_q;
  assign irq_ext_o   = irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: edge/level paths, priority, masking,
// bad completes, claim/edge collision and asynchronous reset.
module tb_ext_irq_ctrl;

  localparam int N = 8;
  localparam logic [1:0] A_EN = 2'd0, A_TRIG = 2'd1, A_PEND = 2'd2, A_CLM = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src_i;
  logic [1:0]   reg_addr_i;
  logic         reg_we_i, reg_re_i;
  logic [31:0]  reg_wdata_i, reg_rdata_o;
  logic         irq_ext_o;
  logic [31:0]  d;

  int n_vec = 0;
  int n_bad = 0;

  ext_irq_ctrl #(.NUM_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n), .src_i(src_i),
    .reg_addr_i(reg_addr_i), .reg_we_i(reg_we_i), .reg_re_i(reg_re_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .irq_ext_o(irq_ext_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    reg_addr_i = a; reg_wdata_i = v; reg_we_i = 1'b1;
    tick();
    reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    reg_addr_i = a; reg_re_i = 1'b1;
    tick();
    reg_re_i = 1'b0;
    v = reg_rdata_o;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_i = src_i | m;
    tick();
    src_i = src_i & ~m;
  endtask

  initial begin
    rst_n = 1'b0; src_i = '0; reg_addr_i = '0;
    reg_we_i = 1'b0; reg_re_i = 1'b0; reg_wdata_i = '0;
    #12;
    chk("reset irq", {31'd0, irq_ext_o}, 32'd0);
    chk("reset rdata", reg_rdata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(4);

    // Edge path on source 0, with exact latency
    wr(A_EN, 32'h01);
    wr(A_TRIG, 32'h01);
    src_i[0] = 1'b1;
    tick();                      // edge N samples the rise
    src_i[0] = 1'b0;
    tick();  chk("edge irq N+1", {31'd0, irq_ext_o}, 32'd0);
    tick();  chk("edge irq N+2", {31'd0, irq_ext_o}, 32'd0);
    rd(A_PEND, d);               // read on edge N+3
    chk("edge pending", d, 32'h01);
    chk("edge irq N+3", {31'd0, irq_ext_o}, 32'd1);
    rd(A_CLM, d);  chk("edge claim id", d, 32'd1);
    tick();  chk("edge irq after claim", {31'd0, irq_ext_o}, 32'd0);
    rd(A_PEND, d); chk("edge pending cleared", d, 32'h00);
    pulse(8'h01); tick(4);       // new edge while in service stays masked
    chk("edge masked in svc", {31'd0, irq_ext_o}, 32'd0);
    wr(A_CLM, 32'd1);            // complete
    tick(2);
    chk("edge irq after cmpl", {31'd0, irq_ext_o}, 32'd1);
    rd(A_CLM, d);  chk("edge reclaim", d, 32'd1);
    wr(A_CLM, 32'd1);

    // Priority: sources 5 and 2 together
    wr(A_EN, 32'hFF);
    wr(A_TRIG, 32'hFF);
    pulse(8'h24); tick(4);
    rd(A_PEND, d); chk("prio pending", d, 32'h24);
    rd(A_CLM, d);  chk("prio claim 1st", d, 32'd3);
    rd(A_CLM, d);  chk("prio claim 2nd", d, 32'd6);
    rd(A_CLM, d);  chk("prio claim none", d, 32'd0);
    wr(A_CLM, 32'd3);
    wr(A_CLM, 32'd6);

    // Level path on source 3
    wr(A_TRIG, 32'h00);
    wr(A_EN, 32'h08);
    src_i[3] = 1'b1;
    tick(4);
    chk("level irq", {31'd0, irq_ext_o}, 32'd1);
    rd(A_CLM, d);  chk("level claim", d, 32'd4);
    tick();  chk("level irq drops", {31'd0, irq_ext_o}, 32'd0);
    wr(A_CLM, 32'd4);
    tick();  chk("level reassert", {31'd0, irq_ext_o}, 32'd1);
    rd(A_CLM, d);  chk("level claim 2", d, 32'd4);
    src_i[3] = 1'b0;
    tick(4);
    wr(A_CLM, 32'd4);
    tick(3); chk("level no reassert", {31'd0, irq_ext_o}, 32'd0);
    rd(A_PEND, d); chk("level pend low", d, 32'h00);

    // Register width and read-before-write on simultaneous strobes
    wr(A_TRIG, 32'hFFFF_FF02);
    rd(A_TRIG, d); chk("trig width", d, 32'h02);
    reg_addr_i = A_EN; reg_wdata_i = 32'h00; reg_we_i = 1'b1; reg_re_i = 1'b1;
    tick();
    reg_we_i = 1'b0; reg_re_i = 1'b0;
    chk("rw pre-write", reg_rdata_o, 32'h08);
    rd(A_EN, d); chk("rw write took", d, 32'h00);

    // Masking and bad completes on source 1
    pulse(8'h02); tick(4);
    chk("mask irq off", {31'd0, irq_ext_o}, 32'd0);
    wr(A_PEND, 32'h00);          // read-only, ignored
    rd(A_PEND, d); chk("mask pending", d, 32'h02);
    rd(A_CLM, d);  chk("mask claim 0", d, 32'd0);
    wr(A_EN, 32'h02);
    chk("mask irq same edge", {31'd0, irq_ext_o}, 32'd0);
    tick();  chk("mask irq next", {31'd0, irq_ext_o}, 32'd1);
    wr(A_CLM, 32'd0);
    wr(A_CLM, 32'd9);
    wr(A_CLM, 32'd2);            // not in service yet: ignored
    rd(A_PEND, d); chk("bad cmpl pending", d, 32'h02);
    chk("bad cmpl irq", {31'd0, irq_ext_o}, 32'd1);
    rd(A_CLM, d);  chk("mask claim 2", d, 32'd2);
    wr(A_CLM, 32'd2);

    // Collision: new edge lands on the claim edge
    wr(A_TRIG, 32'h01);
    wr(A_EN, 32'h01);
    pulse(8'h01); tick(4);
    src_i[0] = 1'b1;
    tick();                      // edge N
    src_i[0] = 1'b0;
    tick();                      // edge N+1
    rd(A_CLM, d);                // claim on edge N+2, same as new edge set
    chk("coll claim", d, 32'd1);
    rd(A_PEND, d); chk("coll pending kept", d, 32'h01);
    wr(A_CLM, 32'd1);
    tick();  chk("coll irq", {31'd0, irq_ext_o}, 32'd1);

    // Asynchronous reset mid-pending, source held high across it
    src_i[0] = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async rst irq", {31'd0, irq_ext_o}, 32'd0);
    chk("async rst rdata", reg_rdata_o, 32'd0);
    tick(2);
    rst_n = 1'b1;
    rd(A_EN, d);   chk("post rst enable", d, 32'h00);
    wr(A_TRIG, 32'h01);
    wr(A_EN, 32'h01);
    tick(4);
    rd(A_PEND, d); chk("post rst no edge", d, 32'h00);
    chk("post rst irq", {31'd0, irq_ext_o}, 32'd0);
    src_i[0] = 1'b0;
    tick(3);
    pulse(8'h01); tick(4);
    rd(A_PEND, d); chk("post rst real edge", d, 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, giving the number of external interrupt sources; the legal range is 1..31.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port src_i, input, NUM_SRC bits: raw asynchronous interrupt sources, active-high.
REQ-005 The block SHALL have port reg_addr_i, input, 2 bits: register select (0 ENABLE, 1 TRIGGER, 2 PENDING, 3 CLAIM).
REQ-006 The block SHALL have port reg_we_i, input, 1 bit: a one-cycle write strobe.
REQ-007 The block SHALL have port reg_re_i, input, 1 bit: a one-cycle read strobe.
REQ-008 The block SHALL have port reg_wdata_i, input, 32 bits: write data.
REQ-009 The block SHALL have port reg_rdata_o, output, 32 bits: registered read data.
REQ-010 The block SHALL have port irq_ext_o, output, 1 bit: registered interrupt request that drives the core irq_ext_i input.

Function
REQ-011 Each src_i bit SHALL pass through a 2-flop synchronizer; edge detect SHALL compare the synchronized value against a third delayed flop.
REQ-012 ENABLE (RW) and TRIGGER (RW; 1 = rising-edge, 0 = level) SHALL each be NUM_SRC bits wide; bits above NUM_SRC SHALL read 0 and ignore writes.
REQ-013 For an edge source, the pending bit SHALL set on a synchronized rising edge and stay latched until claimed.
REQ-014 For a level source, the pending bit SHALL equal the synchronized level AND NOT in-service, unlatched.
REQ-015 Pending SHALL be set regardless of ENABLE; ENABLE only gates participation in irq_ext_o and in claim.
REQ-016 PENDING (RO) reads SHALL return the raw pending vector; writes SHALL be ignored.
REQ-017 An eligible source SHALL be one that is pending, enabled and not in-service; the lowest index has the highest priority.
REQ-018 irq_ext_o SHALL be registered as the OR of all eligible sources.
REQ-019 Latency: a src_i rise sampled at edge N SHALL set pending at N+2, and irq_ext_o SHALL assert at N+3.
REQ-020 A CLAIM read SHALL return ID = index+1 of the highest-priority eligible source, or 0 if none is eligible.
REQ-021 On a non-zero CLAIM read the block SHALL set that source's in-service bit and clear its edge-pending bit in the same cycle.
REQ-022 A CLAIM write with ID 1..NUM_SRC whose in-service bit is set SHALL clear that bit (complete).
REQ-023 A CLAIM write with ID 0, an ID out of range, or an ID not in service SHALL be ignored.
REQ-024 reg_rdata_o SHALL be valid on the cycle after reg_re_i and hold until the next read.
REQ-025 When reg_re_i and reg_we_i are both high, the write SHALL take effect and the read SHALL return pre-write state.
REQ-026 When a new edge and a claim clear hit the same source in the same cycle, set SHALL win and pending SHALL remain 1.
REQ-027 A complete and a claim in the same cycle cannot occur, because reads and writes of CLAIM are separate accesses; if both strobes are high, REQ-025 applies.
REQ-028 A source disabled while in service SHALL keep its in-service bit until completed.

Reset
REQ-029 Assertion of rst_n low SHALL asynchronously clear synchronizers, ENABLE, TRIGGER, pending, in-service, reg_rdata_o and irq_ext_o to 0.
REQ-030 Reset SHALL discard any mid-operation claim, and edges present in the synchronizer at reset SHALL be lost.
REQ-031 After rst_n deassertion, a source already high SHALL NOT produce an edge-pending bit; a level source SHALL pend after 2 cycles.

Verification
REQ-032 Edge path: ENABLE=0x01, TRIGGER=0x01, pulse src_i[0] for 1 cycle at edge N -> pending[0]=1 at N+2, irq_ext_o=1 at N+3; CLAIM read -> 1; irq_ext_o=0 next cycle; write CLAIM=1 -> in-service clears.
REQ-033 Priority: ENABLE=0xFF, TRIGGER=0xFF, raise src_i[5] and src_i[2] together -> successive CLAIM reads return 3, then 6, then 0.
REQ-034 Level path: TRIGGER=0, ENABLE=0x08, hold src_i[3] high -> claim returns 4, irq_ext_o drops; complete with src_i[3] still high -> irq_ext_o reasserts within 1 cycle; complete after src_i[3] falls -> no reassertion.
REQ-035 Masking and bad writes: src_i[1] edge with ENABLE=0 -> PENDING=0x02, irq_ext_o=0, CLAIM read=0; then ENABLE=0x02 -> irq_ext_o=1 on the next cycle; CLAIM writes of 0 and 9 -> no state change.
REQ-036 Collision and reset: a src_i[0] edge lands on the claim cycle -> pending[0] stays 1; assert rst_n mid-pending -> all outputs 0 immediately, asynchronously to clk.
